// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional accepted-request counter is enabled by defining RESET_SEQ_COUNT_EN.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      STRETCH,
      RELEASE,
      RUN,
      SW_ASSERT
   } state_t;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_STRETCH_CYCLES = 16;
   localparam int DEF_NUM_DOMAINS    = 3;
   localparam int DEF_DOMAIN_GAP     = 4;
   localparam int DEF_CNT_W          = 8;

   // Counter width for a limit, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert chain; sync_ok goes high SYNC_STAGES edges after reset lifts.
module reset_sync
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   output logic sync_ok
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-domain reset generator with stretch, ordered release and software reset handshake.
// Define RESET_SEQ_COUNT_EN to build the saturating accepted-request counter on rst_count.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int DOMAIN_GAP     = DEF_DOMAIN_GAP,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sw_req,
   output logic                   sw_ack,
   output logic [NUM_DOMAINS-1:0] dom_rst_n,
   output logic                   all_released,
   output logic [CNT_W-1:0]       rst_count
);

   localparam int STR_W = clog2_min1(STRETCH_CYCLES);
   localparam int GAP_W = clog2_min1(DOMAIN_GAP);
   localparam int IDX_W = clog2_min1(NUM_DOMAINS);

   localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DOMAIN_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

   state_t                 state, state_nxt;
   logic [STR_W-1:0]       str_cnt, str_cnt_nxt;
   logic [GAP_W-1:0]       gap_cnt, gap_cnt_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [NUM_DOMAINS-1:0] dom_nxt;
   logic                   all_nxt;
   logic                   ack_nxt;
   logic                   sw_q;
   logic                   sw_rise;
   logic                   sync_ok;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .sync_ok(sync_ok)
   );

   // sw_q samples sw_req in every state so a level held into RUN is not an edge.
   assign sw_rise = sw_req & ~sw_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= HOLD;
         str_cnt      <= '0;
         gap_cnt      <= '0;
         idx          <= '0;
         dom_rst_n    <= '0;
         all_released <= 1'b0;
         sw_ack       <= 1'b0;
         sw_q         <= 1'b0;
      end else begin
         state        <= state_nxt;
         str_cnt      <= str_cnt_nxt;
         gap_cnt      <= gap_cnt_nxt;
         idx          <= idx_nxt;
         dom_rst_n    <= dom_nxt;
         all_released <= all_nxt;
         sw_ack       <= ack_nxt;
         sw_q         <= sw_req;
      end
   end

   always_comb begin
      state_nxt   = state;
      str_cnt_nxt = '0;
      gap_cnt_nxt = '0;
      idx_nxt     = idx;
      dom_nxt     = dom_rst_n;
      all_nxt     = all_released;
      ack_nxt     = 1'b0;
      case (state)
         HOLD: begin
            if (sync_ok) begin
               state_nxt = STRETCH;
            end
         end
         STRETCH: begin
            if (str_cnt == STR_LAST) begin
               dom_nxt[0] = 1'b1;
               idx_nxt    = '0;
               // With a single domain the entry edge is also the final release.
               if (NUM_DOMAINS == 1) begin
                  all_nxt   = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = RELEASE;
               end
            end else begin
               str_cnt_nxt = str_cnt + STR_W'(1);
            end
         end
         RELEASE: begin
            if (gap_cnt == GAP_LAST) begin
               idx_nxt          = idx + IDX_W'(1);
               dom_nxt[idx_nxt] = 1'b1;
               if (idx_nxt == IDX_LAST) begin
                  all_nxt   = 1'b1;
                  state_nxt = RUN;
               end
            end else begin
               gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
         end
         RUN: begin
            if (sw_rise) begin
               dom_nxt   = '0;
               all_nxt   = 1'b0;
               ack_nxt   = 1'b1;
               state_nxt = SW_ASSERT;
            end
         end
         SW_ASSERT: begin
            state_nxt = STRETCH;
         end
         default: begin
            state_nxt = HOLD;
         end
      endcase
   end

`ifdef RESET_SEQ_COUNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (&value) ? value : value + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_count <= '0;
      end else if (ack_nxt) begin
         rst_count <= sat_inc(rst_count);
      end
   end
`else
   assign rst_count = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected outputs come from edge arithmetic on release times.
module tb_reset_sequencer;

   localparam int SS = 2;
   localparam int SC = 16;
   localparam int ND = 3;
   localparam int DG = 4;
   localparam int CW = 2;
   localparam int VW = ND + 2 + CW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sw_req = 1'b0;
   logic          sw_ack;
   logic [ND-1:0] dom_rst_n;
   logic          all_released;
   logic [CW-1:0] rst_count;
   logic [VW-1:0] obs;

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset release, first release edge of current sequence.
   int e;
   int base;
   int mcnt;
   bit prev_req;
   bit prev_all;
   bit m_ack;

   reset_sequencer #(
      .SYNC_STAGES   (SS),
      .STRETCH_CYCLES(SC),
      .NUM_DOMAINS   (ND),
      .DOMAIN_GAP    (DG),
      .CNT_W         (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw_req      (sw_req),
      .sw_ack      (sw_ack),
      .dom_rst_n   (dom_rst_n),
      .all_released(all_released),
      .rst_count   (rst_count)
   );

   always #5 clk = ~clk;

   assign obs = {dom_rst_n, all_released, sw_ack, rst_count};

   function automatic logic [ND-1:0] exp_dom();
      logic [ND-1:0] d;
      for (int i = 0; i < ND; i++) d[i] = (e >= base + i * DG);
      return d;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [ND-1:0] d;
      d = exp_dom();
      return {d, &d, m_ack, CW'(mcnt)};
   endfunction

   function automatic int sat_exp(input int n);
`ifdef RESET_SEQ_COUNT_EN
      return (n > (2 ** CW - 1)) ? (2 ** CW - 1) : n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic model_reset();
      e        = 0;
      base     = SS + SC + 1;
      mcnt     = 0;
      prev_req = 1'b0;
      prev_all = 1'b0;
      m_ack    = 1'b0;
   endtask

   // Advance one clock edge and update the expected outputs; leaves time at edge+1.
   task automatic model_edge();
      bit req_now;
      @(posedge clk);
      e++;
      req_now = sw_req;
      if (prev_all && req_now && !prev_req) begin
         base  = e + 1 + SC;
         m_ack = 1'b1;
         mcnt  = sat_exp(mcnt + 1);
      end else begin
         m_ack = 1'b0;
      end
      prev_req = req_now;
      #1;
      prev_all = &exp_dom();
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      sw_req = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=%b", obs, exp_vec());
      end
      repeat (5) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", obs, exp_vec());
         end
      end
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL power_up e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
         if (e == 18 || e == 19 || e == 23 || e == 27) begin
            checks++;
            if ((e == 18 && dom_rst_n !== 3'b000) || (e == 19 && dom_rst_n !== 3'b001) ||
                (e == 23 && dom_rst_n !== 3'b011) ||
                (e == 27 && (dom_rst_n !== 3'b111 || all_released !== 1'b1))) begin
               errors++;
               $display("FAIL power_up_table e=%0d dom=%b all=%b", e, dom_rst_n, all_released);
            end
         end
      end
   endtask

   task automatic test_sw_request();
      int n;
      n = $urandom_range(35, 45);
      while (e < n - 1) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL sw_pre e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
      sw_req = 1'b1;
      model_edge();
      sw_req = 1'b0;
      checks++;
      if (sw_ack !== 1'b1 || dom_rst_n !== 3'b000 || all_released !== 1'b0 ||
          rst_count !== CW'(sat_exp(1))) begin
         errors++;
         $display("FAIL sw_accept e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      for (int k = 0; k < 30; k++) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL sw_seq e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
         if (e == n + 16 || e == n + 17 || e == n + 21 || e == n + 25) begin
            checks++;
            if ((e == n + 16 && dom_rst_n !== 3'b000) || (e == n + 17 && dom_rst_n !== 3'b001) ||
                (e == n + 21 && dom_rst_n !== 3'b011) || (e == n + 25 && dom_rst_n !== 3'b111)) begin
               errors++;
               $display("FAIL sw_table e=%0d n=%0d dom=%b", e, n, dom_rst_n);
            end
         end
      end
   endtask

   task automatic test_hold_req();
      int acks;
      acks   = 0;
      sw_req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         model_edge();
         if (sw_ack === 1'b1) acks++;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL hold_seq e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
      checks++;
      if (acks !== 1) begin
         errors++;
         $display("FAIL hold_ack_count got=%0d exp=1", acks);
      end
      sw_req = 1'b0;
      model_edge();
      sw_req = 1'b1;
      model_edge();
      sw_req = 1'b0;
      checks++;
      if (sw_ack !== 1'b1 || obs !== exp_vec()) begin
         errors++;
         $display("FAIL hold_rearm e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      for (int k = 0; k < 30; k++) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL hold_tail e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
   endtask

   task automatic test_glitch();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL glitch_assert got=%b exp=%b", obs, exp_vec());
      end
      #2;
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL glitch_seq e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
   endtask

   task automatic test_stretch_req();
      int p;
      int acks;
      acks = 0;
      p    = $urandom_range(10, 17);
      while (e < 30) begin
         sw_req = (e == p - 1);
         model_edge();
         if (sw_ack === 1'b1) acks++;
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL stretch_req e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
      sw_req = 1'b0;
      checks++;
      if (acks !== 0) begin
         errors++;
         $display("FAIL stretch_ack_count got=%0d exp=0", acks);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      #2;
      reset  = 1'b0;
      sw_req = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL reset_vs_req got=%b exp=%b", obs, exp_vec());
      end
      @(posedge clk);
      #1;
      sw_req = 1'b0;
      reset  = 1'b1;
      k = $urandom_range(5, 26);
      while (e < k) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL mid_pre e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL mid_assert k=%0d got=%b exp=%b", k, obs, exp_vec());
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL mid_hold got=%b exp=%b", obs, exp_vec());
      end
      reset = 1'b1;
      for (int j = 0; j < 30; j++) begin
         model_edge();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL mid_restart e=%0d got=%b exp=%b", e, obs, exp_vec());
         end
      end
   endtask

   task automatic test_saturation();
      for (int j = 0; j < 5; j++) begin
         sw_req = 1'b1;
         model_edge();
         sw_req = 1'b0;
         checks++;
         if (sw_ack !== 1'b1 || rst_count !== CW'(sat_exp(j + 1))) begin
            errors++;
            $display("FAIL sat_count j=%0d ack=%b got=%0d exp=%0d", j, sw_ack, rst_count,
                     sat_exp(j + 1));
         end
         for (int k = 0; k < 26; k++) begin
            model_edge();
            checks++;
            if (obs !== exp_vec()) begin
               errors++;
               $display("FAIL sat_seq e=%0d got=%b exp=%b", e, obs, exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw_request();
      test_hold_req();
      test_glitch();
      test_stretch_req();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
